// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline register: state encoding, entry layout, defaults.
// Latency: n/a (types only). Backpressure: n/a.
package pipe_pkg;

    localparam int          PC_W              = 32;
    localparam int          INSTR_W           = 32;
    localparam int          A3_W_DEFAULT      = 5;
    localparam int          EXC_W_DEFAULT     = 5;
    localparam int          PAYLOAD_W_DEFAULT = 96;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR         = 32'h0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    // Default-width layout of one stage entry; the stage re-declares it with its own parameters.
    typedef struct packed {
        logic [PC_W-1:0]              pc;
        logic [INSTR_W-1:0]           instr;
        logic [A3_W_DEFAULT-1:0]      a3;
        logic [EXC_W_DEFAULT-1:0]     exc;
        logic                         bd;
        logic [PAYLOAD_W_DEFAULT-1:0] data;
    } stage_entry;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall / bubble / flush event counters for one pipeline stage.
// Latency: counts appear one cycle after the event. Backpressure: none, observe-only.
module pipe_stage_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_bubble,
    output logic [15:0] stat_flush
);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stall  <= '0;
            stat_bubble <= '0;
            stat_flush  <= '0;
        end else begin
            if (out_valid && !out_ready && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
            if (!out_valid && (stat_bubble != '1))
                stat_bubble <= stat_bubble + 32'd1;
            if (flush && (stat_flush != '1))
                stat_flush <= stat_flush + 16'd1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready and a one-entry skid buffer; PIPE_STAGE_STATS_EN adds counters.
// Latency: 1 cycle in->out, 1 entry/cycle. Backpressure: in_ready is registered (~skid valid), no comb stall path.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W      = PAYLOAD_W_DEFAULT,
    parameter int          A3_W           = A3_W_DEFAULT,
    parameter int          EXC_W          = EXC_W_DEFAULT,
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter bit          KEEP_BUBBLE_PC = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [A3_W-1:0]      in_a3,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic                 in_bd,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [A3_W-1:0]      out_a3,
    output logic [EXC_W-1:0]     out_exc,
    output logic                 out_bd,
    output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]          stat_stall,
    output logic [31:0]          stat_bubble,
    output logic [15:0]          stat_flush
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
        logic [A3_W-1:0]      a3;
        logic [EXC_W-1:0]     exc;
        logic                 bd;
        logic [PAYLOAD_W-1:0] data;
    } entry_t;

    stage_state_t state_q;
    entry_t       main_q;
    entry_t       skid_q;
    logic         main_vld_q;
    logic         skid_vld_q;

    entry_t       in_entry;
    entry_t       flush_entry;
    entry_t       bubble_entry;
    logic         in_xfer;
    logic         out_xfer;

    assign in_ready = ~skid_vld_q;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_vld_q & out_ready;

    always_comb begin
        in_entry       = '0;
        in_entry.pc    = in_pc;
        in_entry.instr = in_instr;
        in_entry.a3    = in_a3;
        in_entry.exc   = in_exc;
        in_entry.bd    = in_bd;
        in_entry.data  = in_data;

        flush_entry       = '0;
        flush_entry.pc    = RESET_PC;
        flush_entry.instr = NOP_INSTR;

        // A drain bubble is a NOP whose PC/BD is what CP0 would capture as EPC.
        bubble_entry       = '0;
        bubble_entry.instr = NOP_INSTR;
        bubble_entry.pc    = KEEP_BUBBLE_PC ? main_q.pc : RESET_PC;
        bubble_entry.bd    = KEEP_BUBBLE_PC ? main_q.bd : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= ST_EMPTY;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= flush_entry;
            skid_q     <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q     <= in_entry;
                        main_vld_q <= 1'b1;
                        state_q    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_entry;
                    end else if (in_xfer) begin
                        skid_q     <= in_entry;
                        skid_vld_q <= 1'b1;
                        state_q    <= ST_SKID;
                    end else if (out_xfer) begin
                        main_q     <= bubble_entry;
                        main_vld_q <= 1'b0;
                        state_q    <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_q     <= skid_q;
                        skid_vld_q <= 1'b0;
                        state_q    <= ST_FULL;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    main_vld_q <= 1'b0;
                    skid_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = main_vld_q;
    assign out_pc    = main_q.pc;
    assign out_instr = main_q.instr;
    assign out_a3    = main_q.a3;
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;
    assign out_data  = main_q.data;

`ifdef PIPE_STAGE_STATS_EN
    pipe_stage_stats u_stats (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .out_valid   (main_vld_q),
        .out_ready   (out_ready),
        .stat_stall  (stat_stall),
        .stat_bubble (stat_bubble),
        .stat_flush  (stat_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a random run against a queue-based model.
// Two instances share stimulus: KEEP_BUBBLE_PC=1 (dut) and KEEP_BUBBLE_PC=0 (dut0).
module tb_pipe_stage_skid;

    localparam logic [31:0] RPC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  a3;
        logic [4:0]  exc;
        logic        bd;
        logic [95:0] data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, in_valid, out_ready;
    ent_t cur;

    logic        in_ready, out_valid, out_bd;
    logic [31:0] out_pc, out_instr;
    logic [4:0]  out_a3, out_exc;
    logic [95:0] out_data;

    logic        k0_in_ready, k0_out_valid, k0_out_bd;
    logic [31:0] k0_out_pc, k0_out_instr;
    logic [4:0]  k0_out_a3, k0_out_exc;
    logic [95:0] k0_out_data;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stat_stall, stat_bubble, k0_stat_stall, k0_stat_bubble;
    logic [15:0] stat_flush, k0_stat_flush;
    int unsigned m_stall, m_bubble, m_flush;
`endif

    pipe_stage_skid #(.KEEP_BUBBLE_PC(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(cur.pc), .in_instr(cur.instr), .in_a3(cur.a3), .in_exc(cur.exc),
        .in_bd(cur.bd), .in_data(cur.data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_a3(out_a3), .out_exc(out_exc),
        .out_bd(out_bd), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stat_stall(stat_stall), .stat_bubble(stat_bubble), .stat_flush(stat_flush)
`endif
    );

    pipe_stage_skid #(.KEEP_BUBBLE_PC(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(k0_in_ready),
        .in_pc(cur.pc), .in_instr(cur.instr), .in_a3(cur.a3), .in_exc(cur.exc),
        .in_bd(cur.bd), .in_data(cur.data),
        .out_valid(k0_out_valid), .out_ready(out_ready),
        .out_pc(k0_out_pc), .out_instr(k0_out_instr), .out_a3(k0_out_a3), .out_exc(k0_out_exc),
        .out_bd(k0_out_bd), .out_data(k0_out_data)
`ifdef PIPE_STAGE_STATS_EN
        , .stat_stall(k0_stat_stall), .stat_bubble(k0_stat_bubble), .stat_flush(k0_stat_flush)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: entries held by the stage, oldest first; at most two (main + skid).
    ent_t        q[$];
    logic [31:0] last_pc;
    logic        last_bd;

    function automatic ent_t exp_ent();
        ent_t e = '0;
        if (q.size() != 0) e = q[0];
        else begin
            e.pc = last_pc;
            e.bd = last_bd;
        end
        return e;
    endfunction

    function automatic logic [31:0] exp_pc0();
        return (q.size() != 0) ? q[0].pc : RPC;
    endfunction

    function automatic logic exp_bd0();
        return (q.size() != 0) ? q[0].bd : 1'b0;
    endfunction

    task automatic set_cur(input logic [31:0] pc);
        cur.pc    = pc;
        cur.instr = $urandom;
        cur.a3    = 5'($urandom);
        cur.exc   = 5'($urandom);
        cur.bd    = 1'($urandom_range(0, 1));
        cur.data  = {$urandom, $urandom, $urandom};
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic ix, ox;
        ix = in_valid && (q.size() < 2);
        ox = (q.size() != 0) && out_ready;
`ifdef PIPE_STAGE_STATS_EN
        if (reset) begin
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if ((q.size() != 0) && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if ((q.size() == 0) && m_bubble != 32'hFFFF_FFFF) m_bubble++;
            if (flush && m_flush != 32'h0000_FFFF) m_flush++;
        end
`endif
        if (reset || flush) begin
            q.delete();
            last_pc = RPC;
            last_bd = 1'b0;
        end else begin
            if (ox) begin
                last_pc = q[0].pc;
                last_bd = q[0].bd;
                q.delete(0);
            end
            if (ix) q.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        set_cur(32'h0000_4444);
        tick();
        tick();
        reset = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready); else n_pass++;
        n_checks++; if (out_pc !== RPC) $display("FAIL rst_pc got %h want %h", out_pc, RPC); else n_pass++;
        n_checks++; if ({out_instr, out_a3, out_exc, out_bd, out_data} !== '0)
            $display("FAIL rst_fields got %h %h %h %b %h want zeros", out_instr, out_a3, out_exc, out_bd, out_data);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_cur(pcs[i]);
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i])
                $display("FAIL stream_%0d got v=%0b pc=%h want v=1 pc=%h", i, out_valid, out_pc, pcs[i]);
            else n_pass++;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_rdy_%0d got %0b want 1", i, in_ready); else n_pass++;
            n_checks++; if ({out_pc, out_instr, out_a3, out_exc, out_bd, out_data} !== exp_ent())
                $display("FAIL stream_ent_%0d got %h want %h", i, {out_pc, out_instr, out_a3, out_exc, out_bd, out_data}, exp_ent());
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3008)
            $display("FAIL stream_drain got v=%0b pc=%h want v=0 pc=00003008", out_valid, out_pc);
        else n_pass++;
        n_checks++; if (k0_out_pc !== RPC) $display("FAIL stream_drain_k0 got %h want %h", k0_out_pc, RPC); else n_pass++;
    endtask

    task automatic test_skid();
        out_ready = 1'b1; in_valid = 1'b1; set_cur(32'h3000);
        tick();
        out_ready = 1'b0; set_cur(32'h3004);
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h3000)
            $display("FAIL skid_fill got rdy=%0b pc=%h want rdy=0 pc=00003000", in_ready, out_pc);
        else n_pass++;
        set_cur(32'h3008);
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h3000 || out_valid !== 1'b1)
            $display("FAIL skid_hold got rdy=%0b v=%0b pc=%h want rdy=0 v=1 pc=00003000", in_ready, out_valid, out_pc);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h3004 || in_ready !== 1'b1)
            $display("FAIL skid_pop got pc=%h rdy=%0b want pc=00003004 rdy=1", out_pc, in_ready);
        else n_pass++;
        tick();
        n_checks++; if (out_pc !== 32'h3008 || out_valid !== 1'b1)
            $display("FAIL skid_last got pc=%h v=%0b want pc=00003008 v=1", out_pc, out_valid);
        else n_pass++;
        n_checks++; if ({out_pc, out_instr, out_a3, out_exc, out_bd, out_data} !== exp_ent())
            $display("FAIL skid_ent got %h want %h", {out_pc, out_instr, out_a3, out_exc, out_bd, out_data}, exp_ent());
        else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL skid_drain got v=%0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush_skid();
        out_ready = 1'b1; in_valid = 1'b1; set_cur(32'h3020);
        tick();
        out_ready = 1'b0; set_cur(32'h3024);
        tick();
        flush = 1'b1; out_ready = 1'b1; set_cur(32'h3028);
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || out_pc !== RPC || out_instr !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL flush_skid got v=%0b pc=%h instr=%h rdy=%0b want v=0 pc=%h instr=0 rdy=1",
                     out_valid, out_pc, out_instr, in_ready, RPC);
        else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_pc !== RPC)
            $display("FAIL flush_after got v=%0b pc=%h want v=0 pc=%h", out_valid, out_pc, RPC);
        else n_pass++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b1; in_valid = 1'b1; set_cur(32'h3010); cur.bd = 1'b1; cur.exc = 5'd12;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3010 || out_bd !== 1'b1 || out_instr !== 32'h0 || out_exc !== 5'd0)
            $display("FAIL bubble_keep got v=%0b pc=%h bd=%0b instr=%h exc=%h want v=0 pc=00003010 bd=1 instr=0 exc=0",
                     out_valid, out_pc, out_bd, out_instr, out_exc);
        else n_pass++;
        n_checks++; if (out_a3 !== 5'd0 || out_data !== 96'd0)
            $display("FAIL bubble_zero got a3=%h data=%h want 0", out_a3, out_data);
        else n_pass++;
        n_checks++; if (k0_out_pc !== RPC || k0_out_bd !== 1'b0 || k0_out_valid !== 1'b0)
            $display("FAIL bubble_nokeep got pc=%h bd=%0b v=%0b want pc=%h bd=0 v=0", k0_out_pc, k0_out_bd, k0_out_valid, RPC);
        else n_pass++;
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0; in_valid = 1'b1; set_cur(32'h3040);
        tick();
        reset = 1'b1; flush = 1'b1; set_cur(32'h3044);
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== RPC || out_bd !== 1'b0 || out_data !== 96'd0)
            $display("FAIL rst_flush got v=%0b rdy=%0b pc=%h bd=%0b want v=0 rdy=1 pc=%h bd=0", out_valid, in_ready, out_pc, out_bd, RPC);
        else n_pass++;
        out_ready = 1'b1;
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        tick();
        reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; set_cur(32'h3050);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1; flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        n_checks++; if (stat_stall !== 32'd5) $display("FAIL stat_stall got %0d want 5", stat_stall); else n_pass++;
        n_checks++; if (stat_flush !== 16'd2) $display("FAIL stat_flush got %0d want 2", stat_flush); else n_pass++;
        n_checks++; if (stat_bubble !== m_bubble) $display("FAIL stat_bubble got %0d want %0d", stat_bubble, m_bubble); else n_pass++;
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            set_cur(32'h3000 + 32'(c) * 4);
            tick();
            flush = 1'b0;
            n_checks++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                $display("FAIL rnd_ctl c=%0d got v=%0b rdy=%0b want v=%0b rdy=%0b", c, out_valid, in_ready, q.size() != 0, q.size() < 2);
                bad++;
            end else n_pass++;
            n_checks++; if ({out_pc, out_instr, out_a3, out_exc, out_bd, out_data} !== exp_ent()) begin
                $display("FAIL rnd_ent c=%0d got %h want %h", c, {out_pc, out_instr, out_a3, out_exc, out_bd, out_data}, exp_ent());
                bad++;
            end else n_pass++;
            n_checks++; if (k0_out_pc !== exp_pc0() || k0_out_bd !== exp_bd0()) begin
                $display("FAIL rnd_k0 c=%0d got pc=%h bd=%0b want pc=%h bd=%0b", c, k0_out_pc, k0_out_bd, exp_pc0(), exp_bd0());
                bad++;
            end else n_pass++;
`ifdef PIPE_STAGE_STATS_EN
            n_checks++; if (stat_stall !== m_stall || stat_bubble !== m_bubble || stat_flush !== 16'(m_flush)) begin
                $display("FAIL rnd_stats c=%0d got %0d %0d %0d want %0d %0d %0d", c, stat_stall, stat_bubble, stat_flush, m_stall, m_bubble, m_flush);
                bad++;
            end else n_pass++;
`endif
            if (bad > 10) break;
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cur = '0;
        last_pc = RPC; last_bd = 1'b0;
        test_reset();
        test_stream();
        test_skid();
        test_flush_skid();
        test_bubble();
        test_reset_flush();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
